// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: byte handshake toward the host, SPI pins toward the slave.
interface spi_master_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              SCK;
  logic              MOSI;
  logic              MISO;
  logic              CS_n;

  modport master (
    input  tx_data, tx_valid, MISO,
    output tx_ready, rx_data, rx_valid, busy, SCK, MOSI, CS_n
  );

  modport slave (
    output tx_data, tx_valid, MISO,
    input  tx_ready, rx_data, rx_valid, busy, SCK, MOSI, CS_n
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master, one DATA_W-bit frame per accepted word, MSB first.
// Define SPI_MASTER_BURST_EN to chain frames under a single CS_n assertion.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  localparam int CNT_W = 8;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GUARD
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic              sck_reg, sck_next;
  logic              cs_n_reg, cs_n_next;

  logic phase_end;
  logic accept;

  assign phase_end = (cnt_reg == CNT_LAST);
  assign accept    = bus.tx_valid && ready_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = phase_end ? '0 : cnt_reg + CNT_W'(1);
    bit_next      = bit_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (accept) begin
          state_next    = SETUP;
          tx_shift_next = bus.tx_data;
          bit_next      = '0;
        end
      end
      SETUP: begin
        if (phase_end) state_next = SCK_HI;
      end
      SCK_HI: begin
        if (phase_end) begin
          // Sample at the very end of the high phase, furthest from the slave's launch edge.
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], bus.MISO};
          bit_next      = bit_reg + BIT_W'(1);
          state_next    = SCK_LO;
          if (bit_reg != BIT_LAST) tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
        end
      end
      SCK_LO: begin
        if (phase_end) state_next = (bit_reg == BIT_DONE) ? HOLD : SCK_HI;
      end
      HOLD: begin
        if (phase_end) begin
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          state_next    = GUARD;
`ifdef SPI_MASTER_BURST_EN
          if (accept) begin
            state_next    = SETUP;
            tx_shift_next = bus.tx_data;
            bit_next      = '0;
          end
`endif
        end
      end
      GUARD: begin
        if (phase_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Pin-level outputs are registered from the next state so they never glitch.
    busy_next  = (state_next != IDLE);
    sck_next   = (state_next == SCK_HI);
    cs_n_next  = (state_next == IDLE) || (state_next == GUARD);
    ready_next = (state_next == IDLE);
`ifdef SPI_MASTER_BURST_EN
    ready_next = ready_next || ((state_next == HOLD) && (cnt_next == CNT_LAST));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      sck_reg      <= sck_next;
      cs_n_reg     <= cs_n_next;
    end
  end

  assign bus.tx_ready = ready_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.busy     = busy_reg;
  assign bus.SCK      = sck_reg;
  assign bus.MOSI     = tx_shift_reg[DATA_W-1];
  assign bus.CS_n     = cs_n_reg;

endmodule
